// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, defaults and round-robin helper for the uart tx arbiter
// Purpose: FSM state type, parameter defaults and the rr_next search used by rr_pick.
// Ports: none (package).
package uart_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  localparam int unsigned NUM_REQ_DEF        = 4;
  localparam int unsigned DATA_WIDTH_DEF     = 8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  // Widest requester vector the helper handles; narrower arbiters zero-pad.
  localparam int unsigned MAX_REQ = 8;

  // First set bit of req searching cyclically from last+1 over num entries.
  // Returns last unchanged when nothing is requesting.
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         last,
                                         input int                 num);
    int         idx;
    logic [2:0] idx3;
    logic       found;
    found   = 1'b0;
    rr_next = last;
    for (int k = 1; k <= int'(MAX_REQ); k++) begin
      idx  = (int'(last) + k) % num;
      idx3 = 3'(idx);
      if (k <= num && !found && req[idx3]) begin
        found   = 1'b1;
        rr_next = idx3;
      end
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Purpose: picks the next requester after the last grant, cyclically.
// Ports:
//   req   in  NUM_REQ   request vector
//   last  in  ID_WIDTH  index of the previous grant
//   valid out 1         any request present
//   idx   out ID_WIDTH  selected requester (equals last when valid=0)
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = NUM_REQ_DEF,
  parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last,
  output logic                valid,
  output logic [ID_WIDTH-1:0] idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [2:0]         last_ext;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    last_ext               = 3'(last);
    valid                  = |req;
    idx                    = ID_WIDTH'(rr_next(req_ext, last_ext, int'(NUM_REQ)));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter in front of the uart tx stream
// Purpose: shares one byte stream among NUM_REQ requesters, one whole packet at a
//          time, with a watchdog that drops a grant whose requester stalls.
// Ports:
//   clk, rst          serial clock, async active-high reset
//   in_tdata/tvalid/tlast/tready  per-requester byte streams (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   out_tdata/tvalid/tready/tlast registered stream toward the uart
//   busy              high while a grant is held
//   grant_id          current or most recent grant
//   timeout_err       one-cycle pulse when the watchdog aborts a grant
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_tdata,
  input  logic [NUM_REQ-1:0]            in_tvalid,
  input  logic [NUM_REQ-1:0]            in_tlast,
  output logic [NUM_REQ-1:0]            in_tready,
  output logic [DATA_WIDTH-1:0]         out_tdata,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic                          out_tlast,
  output logic                          busy,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          timeout_err
);

  localparam int unsigned         WD_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t            state, state_next;
  logic [ID_WIDTH-1:0]   grant_next;
  logic [WD_WIDTH-1:0]   watchdog, wd_next;
  logic                  timeout_next;
  logic                  pick_valid;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  can_load, accept;
  logic [DATA_WIDTH-1:0] sel_tdata, tdata_next;
  logic                  sel_tlast, tlast_next, tvalid_next;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req   (in_tvalid),
    .last  (grant_id),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy      = (state == ARB_GRANT);
  // Output register can take a beat when empty or draining this cycle.
  assign can_load  = ~out_tvalid | out_tready;
  assign sel_tdata = in_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign sel_tlast = in_tlast[grant_id];
  assign accept    = busy & in_tvalid[grant_id] & can_load;

  // Ready never looks at in_tvalid, so no valid->ready loop through the arbiter.
  always_comb begin
    in_tready = '0;
    if (state == ARB_GRANT) begin
      in_tready[grant_id] = can_load;
    end
  end

  always_comb begin
    state_next   = state;
    grant_next   = grant_id;
    wd_next      = watchdog;
    timeout_next = 1'b0;
    tvalid_next  = out_tvalid;
    tdata_next   = out_tdata;
    tlast_next   = out_tlast;

    if (out_tready) begin
      tvalid_next = 1'b0;
    end
    if (accept) begin
      tvalid_next = 1'b1;
      tdata_next  = sel_tdata;
      tlast_next  = sel_tlast;
    end

    case (state)
      ARB_IDLE: begin
        wd_next = '0;
        if (pick_valid) begin
          grant_next = pick_idx;
          state_next = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (accept) begin
          wd_next = '0;
          if (sel_tlast) begin
            state_next = ARB_IDLE;
          end
        end else if (watchdog == WD_LIMIT) begin
          // Abort leaves grant_id alone so the next search starts after the staller.
          state_next   = ARB_IDLE;
          timeout_next = 1'b1;
          wd_next      = '0;
        end else begin
          wd_next = watchdog + 1'b1;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      grant_id    <= ID_WIDTH'(NUM_REQ - 1);
      watchdog    <= '0;
      timeout_err <= 1'b0;
      out_tvalid  <= 1'b0;
      out_tdata   <= '0;
      out_tlast   <= 1'b0;
    end else begin
      state       <= state_next;
      grant_id    <= grant_next;
      watchdog    <= wd_next;
      timeout_err <= timeout_next;
      out_tvalid  <= tvalid_next;
      out_tdata   <= tdata_next;
      out_tlast   <= tlast_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR*DW-1:0] in_tdata;
  logic [NR-1:0]   in_tvalid, in_tlast, in_tready;
  logic [DW-1:0]   out_tdata;
  logic            out_tvalid, out_tready, out_tlast, busy, timeout_err;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_tdata    (in_tdata),
    .in_tvalid   (in_tvalid),
    .in_tlast    (in_tlast),
    .in_tready   (in_tready),
    .out_tdata   (out_tdata),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tlast   (out_tlast),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         cyc;
  } beat_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [7:0]  qd [NR][$];
  logic        ql [NR][$];
  logic        hold [NR];
  logic        ordy;
  logic [NR-1:0] hs_in;
  beat_t       obeats[$];
  beat_t       exp_b[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      qd[i].delete();
      ql[i].delete();
      hold[i] = 1'b0;
    end
    obeats.delete();
    exp_b.delete();
  endtask

  task automatic push_pkt(input int r, input logic [7:0] b0, input int n);
    for (int k = 0; k < n; k++) begin
      qd[r].push_back(b0 + 8'(k));
      ql[r].push_back(k == n - 1);
    end
  endtask

  task automatic exp_add(input logic [7:0] d, input logic l);
    exp_b.push_back('{d, l, 0});
  endtask

  task automatic drive();
    in_tvalid = '0;
    in_tlast  = '0;
    in_tdata  = '0;
    for (int i = 0; i < NR; i++) begin
      if (qd[i].size() > 0 && !hold[i]) begin
        in_tvalid[i]          = 1'b1;
        in_tlast[i]           = ql[i][0];
        in_tdata[i*DW +: DW]  = qd[i][0];
      end
    end
    out_tready = ordy;
  endtask

  // Called at a negedge: drives, notes which handshakes the coming posedge
  // will take, and returns at the next negedge.
  task automatic step();
    drive();
    #1;
    hs_in = in_tvalid & in_tready;
    if (out_tvalid && out_tready) obeats.push_back('{out_tdata, out_tlast, cyc});
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      if (hs_in[i]) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_log(input string tag, input bit gaps);
    check_eq({tag, "_count"}, obeats.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obeats.size(); i++) begin
      check_eq($sformatf("%s_d%0d", tag, i), obeats[i].d, exp_b[i].d);
      check_eq($sformatf("%s_l%0d", tag, i), obeats[i].l, exp_b[i].l);
      if (gaps && i > 0)
        check_eq($sformatf("%s_gap%0d", tag, i), obeats[i].cyc - obeats[i-1].cyc,
                 exp_b[i-1].l ? 2 : 1);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ordy = 1'b1;
    clear_all();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int j;
    rst  = 1'b1;
    ordy = 1'b1;
    clear_all();
    drive();
    @(negedge clk);

    check_eq("rst_tvalid", out_tvalid, 0);
    check_eq("rst_tdata", out_tdata, 0);
    check_eq("rst_tlast", out_tlast, 0);
    check_eq("rst_tready", in_tready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant_id, 3);
    check_eq("rst_timeout", timeout_err, 0);

    // Single packet from requester 2
    do_reset();
    push_pkt(2, 8'h48, 2);
    step();
    check_eq("sp_grant", grant_id, 2);
    check_eq("sp_busy", busy, 1);
    step();
    check_eq("sp_v0", out_tvalid, 1);
    check_eq("sp_d0", out_tdata, 8'h48);
    check_eq("sp_l0", out_tlast, 0);
    step();
    check_eq("sp_d1", out_tdata, 8'h49);
    check_eq("sp_l1", out_tlast, 1);
    check_eq("sp_busy_end", busy, 0);
    step();
    check_eq("sp_v_end", out_tvalid, 0);
    exp_add(8'h48, 0); exp_add(8'h49, 1);
    check_log("sp", 1);

    // Round-robin fairness: 0,1,3,0
    do_reset();
    push_pkt(0, 8'h01, 3);
    push_pkt(0, 8'h04, 3);
    push_pkt(1, 8'h11, 3);
    push_pkt(3, 8'h31, 3);
    for (int k = 0; k < 100 && obeats.size() < 12; k++) step();
    exp_add(8'h01, 0); exp_add(8'h02, 0); exp_add(8'h03, 1);
    exp_add(8'h11, 0); exp_add(8'h12, 0); exp_add(8'h13, 1);
    exp_add(8'h31, 0); exp_add(8'h32, 0); exp_add(8'h33, 1);
    exp_add(8'h04, 0); exp_add(8'h05, 0); exp_add(8'h06, 1);
    check_log("rr", 1);

    // Backpressure while requester 1 streams
    do_reset();
    push_pkt(1, 8'h10, 4);
    step();
    check_eq("bp_grant", grant_id, 1);
    step();
    check_eq("bp_d0", out_tdata, 8'h10);
    ordy = 1'b0;
    step();
    check_eq("bp_hold1", out_tdata, 8'h10);
    step();
    check_eq("bp_hold2", out_tdata, 8'h10);
    check_eq("bp_hold2_v", out_tvalid, 1);
    ordy = 1'b1;
    repeat (5) step();
    exp_add(8'h10, 0); exp_add(8'h11, 0); exp_add(8'h12, 0); exp_add(8'h13, 1);
    check_log("bp", 0);

    // Watchdog abort of a stalled requester 0
    do_reset();
    push_pkt(0, 8'hAA, 2);
    push_pkt(3, 8'h3C, 1);
    step();
    check_eq("to_grant0", grant_id, 0);
    step();
    check_eq("to_d0", out_tdata, 8'hAA);
    hold[0] = 1'b1;
    j = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (timeout_err) begin
        j = k;
        break;
      end
    end
    check_eq("to_latency", j, TO);
    check_eq("to_busy", busy, 0);
    check_eq("to_keep_grant", grant_id, 0);
    step();
    check_eq("to_pulse_end", timeout_err, 0);
    check_eq("to_next_grant", grant_id, 3);
    check_eq("to_next_busy", busy, 1);
    exp_add(8'hAA, 0);
    check_log("to", 0);

    // Reset in the middle of a 4-byte packet
    do_reset();
    push_pkt(0, 8'h50, 4);
    step();
    step();
    step();
    check_eq("mr_pre_d", out_tdata, 8'h51);
    rst = 1'b1;
    #1;
    check_eq("mr_tvalid", out_tvalid, 0);
    check_eq("mr_tdata", out_tdata, 0);
    check_eq("mr_tlast", out_tlast, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_grant", grant_id, 3);
    check_eq("mr_tready", in_tready, 0);
    check_eq("mr_timeout", timeout_err, 0);
    clear_all();
    push_pkt(1, 8'h70, 1);
    push_pkt(0, 8'h60, 1);
    step();
    rst = 1'b0;
    step();
    check_eq("mr_first_prio", grant_id, 0);
    check_eq("mr_busy_after", busy, 1);

    // New request arriving on the same cycle as a tlast accept
    do_reset();
    push_pkt(1, 8'h21, 2);
    step();
    check_eq("ct_grant1", grant_id, 1);
    step();
    push_pkt(2, 8'h31, 1);
    step();
    check_eq("ct_idle", busy, 0);
    check_eq("ct_grant_kept", grant_id, 1);
    step();
    check_eq("ct_grant2", grant_id, 2);
    check_eq("ct_busy2", busy, 1);
    step();
    step();
    exp_add(8'h21, 0); exp_add(8'h22, 1); exp_add(8'h31, 1);
    check_log("ct", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit stream (AXI-stream style tdata/tvalid/tready into the uart core) among NUM_REQ independent byte-stream requesters.
- Grants one requester at a time and holds the grant for a whole packet, until that requester's tlast beat is accepted.
- Selects the next requester round-robin.
- Watchdog timeout releases a grant held by a requester that stalls mid-packet.
- Sits between the top-level logic and the uart instance, in the serial clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width per beat.
- TIMEOUT_CYCLES, 1024, cycles without an accepted beat while granted before the grant is aborted (>=2).
- ID_WIDTH, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  in  1  serial clock.
- rst  in  1  asynchronous, active-high reset.
- in_tdata  in  NUM_REQ*DATA_WIDTH  requester bytes; requester i occupies bits [i*8 +: 8].
- in_tvalid  in  NUM_REQ  per-requester valid.
- in_tlast  in  NUM_REQ  per-requester last-beat-of-packet.
- in_tready  out  NUM_REQ  per-requester ready; at most one bit high.
- out_tdata  out  DATA_WIDTH  byte to uart input_axis_tdata.
- out_tvalid  out  1  to uart input_axis_tvalid.
- out_tready  in  1  from uart input_axis_tready.
- out_tlast  out  1  last beat of the forwarded packet (monitor only).
- busy  out  1  high while in GRANT state.
- grant_id  out  ID_WIDTH  index of the current or most recent grant.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values: out_tvalid=0, out_tdata=0, out_tlast=0, in_tready=0, busy=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), timeout_err=0, watchdog=0, state=IDLE.
- FSM IDLE:
  - If any in_tvalid is set, pick the first set bit searching cyclically from grant_id+1.
  - Register it into grant_id and go to GRANT next cycle. No beat is accepted in IDLE.
- FSM GRANT:
  - in_tready[grant_id] = ~out_tvalid | out_tready; all other ready bits are 0.
  - Accept = in_tvalid[g] & in_tready[g]. On accept, load the output register (tdata, tlast, out_tvalid=1) and clear the watchdog.
  - If the accepted beat has tlast=1, go to IDLE next cycle.
- Output register:
  - out_tvalid clears when out_tready=1 and no new accept occurs in the same cycle.
  - Data is held stable while out_tvalid=1 and out_tready=0.
- Latency: an accepted beat appears on out_* the next cycle.
  - One bubble cycle (IDLE) between packets; back-to-back packets run at most 1 beat per cycle minus that bubble.
- Round-robin example: grant_id=1 with requests {0,2,3} -> next grant is 2. A sole requester is re-granted after its bubble.
- Watchdog:
  - In GRANT, increments every cycle with no accept; saturates.
  - When it reaches TIMEOUT_CYCLES-1 with no accept: go to IDLE, pulse timeout_err for 1 cycle, grant_id is retained.
  - Any pending out_tvalid beat still drains normally; no fabricated tlast.
  - The watchdog is held at 0 in IDLE.
- Downstream backpressure (out_tready=0) also counts toward the timeout. The uart always drains eventually, so an abort is only expected for a stalled requester. This is intentional.
- Simultaneous events:
  - A tlast accept and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - A tlast accept and watchdog expiry in the same cycle cannot both happen (accept clears the watchdog). Accept wins.
- A requester dropping tvalid mid-packet is legal; its grant is held until it finishes or the watchdog expires.
- rst asserted mid-packet: everything clears immediately, including a pending output beat, which is lost. The bench must not expect it.
- No combinational path from in_tvalid to in_tready. Ready depends only on state, grant_id, out_tvalid and out_tready.

Decomposition:
- Package uart_arb_pkg:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
  - localparam defaults for NUM_REQ, DATA_WIDTH, TIMEOUT_CYCLES;
  - function rr_next(req, last) returning the next index.
- Sub-module rr_pick (combinational round-robin selector: req vector + last index -> valid + index). Reused by later arbiters.

Test Plan:
- Single packet: requester 2 sends 0x48,0x49 (tlast on 0x49), out_tready=1.
  - grant_id=2 one cycle after tvalid; out bytes 0x48 then 0x49 on consecutive cycles; busy falls after tlast.
- Round-robin fairness: requesters 0,1,3 each hold a 3-byte packet pending from reset.
  - Output packet order is 0,1,3,0 with a 1-cycle bubble between packets; no byte interleaving.
- Backpressure: out_tready toggles 1,0,0,1 while requester 1 streams 0x10..0x13.
  - out_tdata held stable while stalled; every byte appears exactly once, in order.
- Timeout: TIMEOUT_CYCLES=16; requester 0 sends 0xAA (tlast=0) then drops tvalid.
  - timeout_err pulses exactly 16 cycles after the accept; busy=0; requester 3's pending packet is granted next.
- Reset mid-packet: rst pulsed during byte 2 of 4.
  - All outputs return to reset values asynchronously; after release, requester 0 has first priority.
- Contention on tlast: requester 1 finishes while requester 2 raises tvalid in the same cycle.
  - Exactly one IDLE cycle, then grant_id=2.
